array_feeder: RTL and testbench

ARRAY_FEEDER -- requirements
Module: array_feeder

---
 rtl/array_feeder_pkg.sv | 21 ++
 rtl/feeder_cnt.sv | 28 ++
 rtl/array_feeder.sv | 169 ++++++++++++++++
 tb/tb_array_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_feeder_pkg.sv
// Shared types and default sizes for the systolic-array feeder.
// Imported by the feeder top and its counter.
package array_feeder_pkg;

    localparam int HEIGHT  = 12;
    localparam int WIDTH   = 14;
    localparam int IWIDTH  = 8;
    localparam int OWIDTH  = 24;
    localparam int MAC_CYC = 8;
    localparam int KW      = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FETCH,
        MAC,
        DRAIN,
        CLEAR
    } state_t;

endpackage

// File: rtl/feeder_cnt.sv
// Terminal-count counter: counts enabled cycles, wraps to 0 after reaching limit.
// tc is high while the count equals limit.
module feeder_cnt
    import array_feeder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/array_feeder.sv
// Sequences weight load, ifm fetch, binary-serial MAC, result drain and clear
// for one tile pass through a HEIGHT x WIDTH systolic array.
module array_feeder
    import array_feeder_pkg::*;
#(
    parameter int HEIGHT  = array_feeder_pkg::HEIGHT,
    parameter int WIDTH   = array_feeder_pkg::WIDTH,
    parameter int IWIDTH  = array_feeder_pkg::IWIDTH,
    parameter int OWIDTH  = array_feeder_pkg::OWIDTH,
    parameter int MAC_CYC = array_feeder_pkg::MAC_CYC,
    parameter int KW      = array_feeder_pkg::KW
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic        [KW-1:0]                  k_len,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic signed [WIDTH-1:0][IWIDTH-1:0]   w_data,
    input  logic                                  i_valid,
    output logic                                  i_ready,
    input  logic signed [HEIGHT-1:0][IWIDTH-1:0]  i_data,
    output logic        [HEIGHT-1:0]              en_i,
    output logic        [HEIGHT-1:0]              clr_i,
    output logic        [HEIGHT-1:0]              mac_done,
    output logic        [WIDTH-1:0]               en_w,
    output logic        [WIDTH-1:0]               clr_w,
    output logic        [WIDTH-1:0]               en_o,
    output logic        [WIDTH-1:0]               clr_o,
    output logic signed [HEIGHT-1:0][IWIDTH-1:0]  ifm,
    output logic signed [WIDTH-1:0][IWIDTH-1:0]   wght,
    input  logic signed [WIDTH-1:0][OWIDTH-1:0]   ofm,
    output logic                                  o_valid,
    input  logic                                  o_ready,
    output logic signed [WIDTH-1:0][OWIDTH-1:0]   o_data
);

    localparam int BW = $clog2(HEIGHT + 1);
    localparam int MW = (MAC_CYC > 1) ? $clog2(MAC_CYC) : 1;

    state_t state;
    state_t next;

    logic        [KW-1:0]                 k_q;
    logic signed [HEIGHT-1:0][IWIDTH-1:0] ifm_q;
    logic                                 zero_done;

    logic w_acc;
    logic i_acc;
    logic o_acc;
    logic beat_tc;
    logic mac_tc;
    logic k_tc;
    logic idle;

    assign idle  = (state == IDLE);
    assign w_acc = (state == LOAD_W) && w_valid;
    assign i_acc = (state == FETCH) && i_valid;
    assign o_acc = (state == DRAIN) && o_ready;

    // One beat counter serves both weight load and result drain.
    feeder_cnt #(.W(BW)) u_beat (
        .clk   (clk),
        .rst   (rst),
        .en    (w_acc || o_acc),
        .clr   (idle),
        .limit (BW'(HEIGHT - 1)),
        .tc    (beat_tc)
    );

    feeder_cnt #(.W(MW)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (state == MAC),
        .clr   (idle),
        .limit (MW'(MAC_CYC - 1)),
        .tc    (mac_tc)
    );

    feeder_cnt #(.W(KW)) u_k (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == MAC) && mac_tc),
        .clr   (idle),
        .limit (k_q - 1'b1),
        .tc    (k_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_q       <= '0;
            ifm_q     <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= next;
            zero_done <= idle && start && (k_len == '0);
            if (idle && start) begin
                k_q <= k_len;
            end
            if (i_acc) begin
                ifm_q <= i_data;
            end
        end
    end

    always_comb begin
        next     = state;
        busy     = !idle;
        done     = zero_done;
        w_ready  = 1'b0;
        i_ready  = 1'b0;
        o_valid  = 1'b0;
        en_w     = '0;
        en_i     = '0;
        en_o     = '0;
        mac_done = '0;
        clr_i    = '0;
        clr_w    = '0;
        clr_o    = '0;
        wght     = '0;
        ifm      = '0;
        o_data   = '0;
        unique case (state)
            IDLE: begin
                if (start && (k_len != '0)) next = LOAD_W;
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    en_w = '1;
                    wght = w_data;
                    if (beat_tc) next = FETCH;
                end
            end
            FETCH: begin
                i_ready = 1'b1;
                if (i_valid) next = MAC;
            end
            MAC: begin
                en_i = '1;
                ifm  = ifm_q;
                if (mac_tc) begin
                    mac_done = '1;
                    next     = k_tc ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                o_valid = 1'b1;
                o_data  = ofm;
                if (o_ready) begin
                    en_o = '1;
                    if (beat_tc) next = CLEAR;
                end
            end
            CLEAR: begin
                clr_i = '1;
                clr_w = '1;
                clr_o = '1;
                done  = 1'b1;
                next  = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_array_feeder.sv
// Self-checking bench for array_feeder on a 2x2 array with 4-cycle MACs.
// Pass-level expectations come from handshake counts and the latency formula.
module tb_array_feeder;

    localparam int H  = 2;
    localparam int W  = 2;
    localparam int IW = 8;
    localparam int OW = 24;
    localparam int M  = 4;
    localparam int KW = 10;
    localparam int WB = W * IW;
    localparam int IB = H * IW;
    localparam int OB = W * OW;

    localparam logic [H-1:0] ALLH = '1;
    localparam logic [W-1:0] ALLW = '1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [KW-1:0] k_len;
    logic busy;
    logic done;
    logic w_valid;
    logic w_ready;
    logic signed [W-1:0][IW-1:0] w_data;
    logic i_valid;
    logic i_ready;
    logic signed [H-1:0][IW-1:0] i_data;
    logic [H-1:0] en_i;
    logic [H-1:0] clr_i;
    logic [H-1:0] mac_done;
    logic [W-1:0] en_w;
    logic [W-1:0] clr_w;
    logic [W-1:0] en_o;
    logic [W-1:0] clr_o;
    logic signed [H-1:0][IW-1:0] ifm;
    logic signed [W-1:0][IW-1:0] wght;
    logic signed [W-1:0][OW-1:0] ofm;
    logic o_valid;
    logic o_ready;
    logic signed [W-1:0][OW-1:0] o_data;

    int checks = 0;
    int errors = 0;

    array_feeder #(
        .HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .OWIDTH(OW),
        .MAC_CYC(M), .KW(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done),
        .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
        .ifm(ifm), .wght(wght), .ofm(ofm),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        w_valid = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        w_data  = '0;
        i_data  = '0;
        ofm     = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdy"}, {w_ready, i_ready, o_valid}, 0);
        chk({tag, "_en"}, {en_i, en_w, en_o, mac_done}, 0);
        chk({tag, "_clr"}, {clr_i, clr_w, clr_o}, 0);
        chk({tag, "_ops"}, {ifm, wght}, 0);
    endtask

    // One full pass; stalls are inserted before weight beat wsa, fetch isa
    // and drain beat osa, each lasting the given number of cycles.
    task automatic run_pass(input int k, input int wsa, input int ws,
                            input int isa, input int is_n,
                            input int osa, input int os, input bit poke);
        logic signed [W-1:0][IW-1:0] wv [H];
        logic signed [W-1:0][OW-1:0] ov [H];
        logic signed [H-1:0][IW-1:0] hold;
        int wb, fb, ob, eni, md, dn, dcyc, clrs, bsy, exp_cyc;
        int wsl, isl, osl;
        wb = 0; fb = 0; ob = 0; eni = 0; md = 0;
        dn = 0; dcyc = -1; clrs = 0; bsy = 0;
        wsl = ws; isl = is_n; osl = os;
        hold = '0;
        for (int i = 0; i < H; i++) begin
            wv[i] = WB'($urandom);
            ov[i] = OB'({$urandom, $urandom});
        end
        exp_cyc = (k == 0) ? 1 : 2 * H + k * (M + 1) + 1 + ws + is_n + os;

        @(negedge clk);
        idle_inputs();
        start = 1'b1;
        k_len = KW'(k);

        for (int c = 1; c <= exp_cyc + 3; c++) begin
            @(negedge clk);
            start = poke && (c == 2);
            k_len = KW'($urandom);
            w_valid = 1'b0;
            if (w_ready) begin
                if (wb == wsa && wsl > 0) wsl--;
                else w_valid = 1'b1;
            end
            w_data = (w_valid && wb < H) ? wv[wb] : WB'($urandom);
            i_valid = 1'b0;
            if (i_ready) begin
                if (fb == isa && isl > 0) isl--;
                else i_valid = 1'b1;
            end
            i_data = IB'($urandom);
            o_ready = 1'b0;
            if (o_valid) begin
                if (ob == osa && osl > 0) osl--;
                else o_ready = 1'b1;
            end
            ofm = (ob < H) ? ov[ob] : OB'({$urandom, $urandom});
            #1;
            if (w_valid && w_ready && wb < H) begin
                chk("en_w", en_w, ALLW);
                chk("wght", wght, wv[wb]);
                wb++;
            end else begin
                chk("en_w_off", en_w, 0);
                chk("wght_off", wght, 0);
            end
            if (i_ready && !i_valid) chk("en_i_stall", en_i, 0);
            if (i_valid && i_ready) begin
                chk("en_i_fetch", en_i, 0);
                hold = i_data;
                fb++;
            end
            if (en_i != 0) begin
                chk("en_i", en_i, ALLH);
                chk("ifm", ifm, hold);
                eni++;
            end else begin
                chk("ifm_off", ifm, 0);
            end
            if (mac_done != 0) begin
                md++;
                chk("mac_done_w", mac_done, ALLH);
                chk("mac_done_pos", eni % M, 0);
            end
            if (o_valid && o_ready && ob < H) begin
                chk("o_data", o_data, ov[ob]);
                chk("en_o", en_o, ALLW);
                ob++;
            end else begin
                chk("en_o_off", en_o, 0);
            end
            if ((clr_i | clr_w | clr_o) != 0) begin
                clrs++;
                chk("clr_all", {clr_i, clr_w, clr_o}, {ALLH, ALLW, ALLW});
                chk("clr_done", done, 1);
            end
            if (busy) bsy++;
            if (done) begin
                dn++;
                dcyc = c;
            end
        end
        idle_inputs();

        chk("done_count", dn, 1);
        chk("done_cycle", dcyc, exp_cyc);
        chk("w_beats", wb, (k > 0) ? H : 0);
        chk("fetches", fb, k);
        chk("en_i_cycles", eni, k * M);
        chk("mac_done_n", md, k);
        chk("o_beats", ob, (k > 0) ? H : 0);
        chk("clears", clrs, (k > 0) ? 1 : 0);
        chk("busy_cycles", bsy, (k > 0) ? exp_cyc : 0);
    endtask

    initial begin
        int dn;
        idle_inputs();
        k_len = '0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("reset");

        // Nominal pass: 2 + 3*5 + 2 + 1 = 20 cycles.
        run_pass(3, 99, 0, 99, 0, 99, 0, 1'b0);
        // Zero-length reduction completes with a lone done pulse.
        run_pass(0, 99, 0, 99, 0, 99, 0, 1'b0);
        // Ifm stall before the second fetch.
        run_pass(3, 99, 0, 1, 5, 99, 0, 1'b0);
        // Drain backpressure.
        run_pass(2, 99, 0, 99, 0, 0, 3, 1'b0);
        // Weight stall plus a start pulse while busy.
        run_pass(2, 1, 2, 99, 0, 99, 0, 1'b1);

        // Abort in the second MAC cycle.
        @(negedge clk);
        idle_inputs();
        start = 1'b1;
        k_len = KW'(2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start   = 1'b0;
            w_valid = 1'b1;
            i_valid = 1'b1;
            o_ready = 1'b1;
            i_data  = IB'($urandom);
        end
        @(negedge clk);
        #1;
        chk("abort_in_mac", en_i, ALLH);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_quiet("abort");
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        run_pass(2, 99, 0, 99, 0, 99, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int k;
            k = int'($urandom_range(1, 6));
            run_pass(k,
                     int'($urandom_range(0, H - 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, k - 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, H - 1)), int'($urandom_range(0, 3)),
                     1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
